// File: rtl/sdram_arbiter_pkg.sv
// Shared SDRAM definitions: command encodings, default bus widths and the
// arbiter state/grant encodings used by engines, debug decode and benches.
package sdram_arbiter_pkg;

  localparam int SDR_ADDR_BITS = 12;
  localparam int SDR_BA_BITS   = 2;
  localparam int SDR_DQ_BITS   = 8;
  localparam int SDR_BURST_LEN = 4;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef enum logic [2:0] {
    ARB_INIT  = 3'd0,
    ARB_IDLE  = 3'd1,
    ARB_AREF  = 3'd2,
    ARB_WRITE = 3'd3,
    ARB_READ  = 3'd4
  } arb_state_t;

  typedef enum logic {
    GNT_READ  = 1'b0,
    GNT_WRITE = 1'b1
  } grant_t;

endpackage

// File: rtl/sdram_pin_reg.sv
// Registered SDRAM pin stage: cmd/addr/ba/dq/oe captured together so every
// pin sees the same one-cycle latency; resets to a NOP with DQ released.
module sdram_pin_reg
  import sdram_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = SDR_ADDR_BITS,
  parameter int BA_BITS   = SDR_BA_BITS,
  parameter int DQ_BITS   = SDR_DQ_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [3:0]           cmd_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [BA_BITS-1:0]   ba_i,
  input  logic [DQ_BITS-1:0]   dq_i,
  input  logic                 oe_i,
  output logic [3:0]           cmd_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [BA_BITS-1:0]   ba_o,
  output logic [DQ_BITS-1:0]   dq_o,
  output logic                 oe_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmd_o  <= CMD_NOP;
      addr_o <= '0;
      ba_o   <= '0;
      dq_o   <= '0;
      oe_o   <= 1'b0;
    end else begin
      cmd_o  <= cmd_i;
      addr_o <= addr_i;
      ba_o   <= ba_i;
      dq_o   <= dq_i;
      oe_o   <= oe_i;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: grants the bus to init, refresh, write or read and
// muxes the owner's command/address/data onto a registered pin stage.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = SDR_ADDR_BITS,
  parameter int BA_BITS   = SDR_BA_BITS,
  parameter int DQ_BITS   = SDR_DQ_BITS,
  parameter int BURST_LEN = SDR_BURST_LEN
) (
  input  logic                 sdram_clk,
  input  logic                 rst_n,
  input  logic                 init_done,
  input  logic [3:0]           init_cmd,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic                 aref_req,
  input  logic [3:0]           aref_cmd,
  input  logic                 aref_done,
  output logic                 aref_en,
  input  logic                 wr_req,
  input  logic [3:0]           wr_cmd,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [BA_BITS-1:0]   wr_ba,
  input  logic [DQ_BITS-1:0]   wr_data,
  input  logic                 wr_go_aref,
  input  logic                 wr_done_all,
  output logic                 wr_en,
  input  logic                 rd_req,
  input  logic [3:0]           rd_cmd,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic [BA_BITS-1:0]   rd_ba,
  input  logic                 rd_go_aref,
  input  logic                 rd_done_all,
  output logic                 rd_en,
  output logic [3:0]           sdram_cmd,
  output logic [ADDR_BITS-1:0] sdram_addr,
  output logic [BA_BITS-1:0]   sdram_ba,
  output logic [DQ_BITS-1:0]   sdram_dq_out,
  output logic                 sdram_dq_oe
);

  localparam int               CNT_W    = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST_LEN);

  arb_state_t       state_q, state_d;
  grant_t           last_grant_q, last_grant_d;
  logic             aref_pend_q, aref_pend_d;
  logic [CNT_W-1:0] oe_cnt_q, oe_cnt_d;
  logic             aref_en_q, aref_en_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;

  logic [3:0]           pin_cmd_d;
  logic [ADDR_BITS-1:0] pin_addr_d;
  logic [BA_BITS-1:0]   pin_ba_d;
  logic [DQ_BITS-1:0]   pin_dq_d;
  logic                 pin_oe_d;

  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_INIT;
      last_grant_q <= GNT_READ;
      aref_pend_q  <= 1'b0;
      oe_cnt_q     <= '0;
      aref_en_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      aref_pend_q  <= aref_pend_d;
      oe_cnt_q     <= oe_cnt_d;
      aref_en_q    <= aref_en_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
    end
  end

  // A request arriving in the same idle cycle already beats write/read.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_INIT:  if (init_done) state_d = ARB_IDLE;
      ARB_IDLE: begin
        if (aref_pend_q || aref_req) begin
          state_d = ARB_AREF;
        end else if (wr_req && (!rd_req || last_grant_q == GNT_READ)) begin
          state_d      = ARB_WRITE;
          last_grant_d = GNT_WRITE;
        end else if (rd_req) begin
          state_d      = ARB_READ;
          last_grant_d = GNT_READ;
        end
      end
      ARB_AREF:  if (aref_done) state_d = ARB_IDLE;
      ARB_WRITE: if (wr_go_aref || wr_done_all) state_d = ARB_IDLE;
      ARB_READ:  if (rd_go_aref || rd_done_all) state_d = ARB_IDLE;
      default:   state_d = ARB_INIT;
    endcase
    aref_en_d   = (state_q == ARB_IDLE) && (state_d == ARB_AREF);
    wr_en_d     = (state_q == ARB_IDLE) && (state_d == ARB_WRITE);
    rd_en_d     = (state_q == ARB_IDLE) && (state_d == ARB_READ);
    aref_pend_d = aref_req | (aref_pend_q & ~aref_en_q);
  end

  // oe is taken from the next count so it reaches the pins with the WR command.
  always_comb begin
    pin_cmd_d  = CMD_NOP;
    pin_addr_d = '0;
    pin_ba_d   = '0;
    pin_dq_d   = '0;
    oe_cnt_d   = '0;
    case (state_q)
      ARB_INIT: begin
        pin_cmd_d  = init_cmd;
        pin_addr_d = init_addr;
      end
      ARB_AREF:  pin_cmd_d = aref_cmd;
      ARB_WRITE: begin
        pin_cmd_d  = wr_cmd;
        pin_addr_d = wr_addr;
        pin_ba_d   = wr_ba;
        pin_dq_d   = wr_data;
        if (wr_cmd == CMD_WR)     oe_cnt_d = CNT_LOAD;
        else if (oe_cnt_q != '0)  oe_cnt_d = oe_cnt_q - CNT_ONE;
      end
      ARB_READ: begin
        pin_cmd_d  = rd_cmd;
        pin_addr_d = rd_addr;
        pin_ba_d   = rd_ba;
      end
      default: ;
    endcase
    pin_oe_d = (oe_cnt_d != '0);
  end

  sdram_pin_reg #(
    .ADDR_BITS(ADDR_BITS),
    .BA_BITS  (BA_BITS),
    .DQ_BITS  (DQ_BITS)
  ) u_pin_reg (
    .clk_i  (sdram_clk),
    .rst_n_i(rst_n),
    .cmd_i  (pin_cmd_d),
    .addr_i (pin_addr_d),
    .ba_i   (pin_ba_d),
    .dq_i   (pin_dq_d),
    .oe_i   (pin_oe_d),
    .cmd_o  (sdram_cmd),
    .addr_o (sdram_addr),
    .ba_o   (sdram_ba),
    .dq_o   (sdram_dq_out),
    .oe_o   (sdram_dq_oe)
  );

  assign aref_en = aref_en_q;
  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized
// traffic compared each cycle against a bus-ownership reference model.
module tb_sdram_arbiter;

  localparam int BURST_LEN = 4;

  logic        sdram_clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic [3:0]  init_cmd;
  logic [11:0] init_addr;
  logic        aref_req;
  logic [3:0]  aref_cmd;
  logic        aref_done;
  logic        aref_en;
  logic        wr_req;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  wr_ba;
  logic [7:0]  wr_data;
  logic        wr_go_aref;
  logic        wr_done_all;
  logic        wr_en;
  logic        rd_req;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_ba;
  logic        rd_go_aref;
  logic        rd_done_all;
  logic        rd_en;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic [7:0]  sdram_dq_out;
  logic        sdram_dq_oe;

  sdram_arbiter dut (
    .sdram_clk   (sdram_clk),
    .rst_n       (rst_n),
    .init_done   (init_done),
    .init_cmd    (init_cmd),
    .init_addr   (init_addr),
    .aref_req    (aref_req),
    .aref_cmd    (aref_cmd),
    .aref_done   (aref_done),
    .aref_en     (aref_en),
    .wr_req      (wr_req),
    .wr_cmd      (wr_cmd),
    .wr_addr     (wr_addr),
    .wr_ba       (wr_ba),
    .wr_data     (wr_data),
    .wr_go_aref  (wr_go_aref),
    .wr_done_all (wr_done_all),
    .wr_en       (wr_en),
    .rd_req      (rd_req),
    .rd_cmd      (rd_cmd),
    .rd_addr     (rd_addr),
    .rd_ba       (rd_ba),
    .rd_go_aref  (rd_go_aref),
    .rd_done_all (rd_done_all),
    .rd_en       (rd_en),
    .sdram_cmd   (sdram_cmd),
    .sdram_addr  (sdram_addr),
    .sdram_ba    (sdram_ba),
    .sdram_dq_out(sdram_dq_out),
    .sdram_dq_oe (sdram_dq_oe)
  );

  always #5 sdram_clk = ~sdram_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, whether a refresh is owed, who won
  // the last write/read tie, and how long ago the last write burst started.
  string       m_owner;
  bit          m_ref_owed;
  bit          m_write_was_last;
  int          m_wr_age;
  logic [3:0]  e_cmd;
  logic [11:0] e_addr;
  logic [1:0]  e_ba;
  logic [7:0]  e_dq;
  logic        e_oe, e_aref_en, e_wr_en, e_rd_en;

  task automatic model_reset();
    m_owner = "init"; m_ref_owed = 0; m_write_was_last = 0; m_wr_age = BURST_LEN;
    e_cmd = 4'b0111; e_addr = '0; e_ba = '0; e_dq = '0; e_oe = 0;
    e_aref_en = 0; e_wr_en = 0; e_rd_en = 0;
  endtask

  task automatic model_step();
    bit want_ref;
    e_cmd = 4'b0111; e_addr = '0; e_ba = '0; e_dq = '0;
    if (m_owner == "init") begin
      e_cmd = init_cmd; e_addr = init_addr;
    end else if (m_owner == "refresh") begin
      e_cmd = aref_cmd;
    end else if (m_owner == "write") begin
      e_cmd = wr_cmd; e_addr = wr_addr; e_ba = wr_ba; e_dq = wr_data;
    end else if (m_owner == "read") begin
      e_cmd = rd_cmd; e_addr = rd_addr; e_ba = rd_ba;
    end
    if (m_owner == "write") begin
      if (wr_cmd == 4'b0100) m_wr_age = 0;
      else if (m_wr_age < BURST_LEN) m_wr_age++;
    end else begin
      m_wr_age = BURST_LEN;
    end
    e_oe = (m_wr_age < BURST_LEN);
    want_ref   = m_ref_owed | aref_req;
    m_ref_owed = aref_req | (m_ref_owed & ~e_aref_en);
    e_aref_en = 0; e_wr_en = 0; e_rd_en = 0;
    if (m_owner == "init") begin
      if (init_done) m_owner = "idle";
    end else if (m_owner == "idle") begin
      if (want_ref) begin
        m_owner = "refresh"; e_aref_en = 1;
      end else if (wr_req && rd_req) begin
        if (m_write_was_last) begin m_owner = "read"; e_rd_en = 1; end
        else begin m_owner = "write"; e_wr_en = 1; end
        m_write_was_last = !m_write_was_last;
      end else if (wr_req) begin
        m_owner = "write"; e_wr_en = 1; m_write_was_last = 1;
      end else if (rd_req) begin
        m_owner = "read"; e_rd_en = 1; m_write_was_last = 0;
      end
    end else if (m_owner == "refresh") begin
      if (aref_done) m_owner = "idle";
    end else if (m_owner == "write") begin
      if (wr_go_aref || wr_done_all) m_owner = "idle";
    end else if (m_owner == "read") begin
      if (rd_go_aref || rd_done_all) m_owner = "idle";
    end
  endtask

  task automatic check_model();
    chk_eq("m_cmd",     32'(sdram_cmd),    32'(e_cmd));
    chk_eq("m_addr",    32'(sdram_addr),   32'(e_addr));
    chk_eq("m_ba",      32'(sdram_ba),     32'(e_ba));
    chk_eq("m_dq",      32'(sdram_dq_out), 32'(e_dq));
    chk_eq("m_oe",      32'(sdram_dq_oe),  32'(e_oe));
    chk_eq("m_aref_en", 32'(aref_en),      32'(e_aref_en));
    chk_eq("m_wr_en",   32'(wr_en),        32'(e_wr_en));
    chk_eq("m_rd_en",   32'(rd_en),        32'(e_rd_en));
  endtask

  task automatic tick();
    model_step();
    @(posedge sdram_clk);
    #1;
    check_model();
  endtask

  task automatic quiet_inputs();
    init_cmd = 4'b0111; init_addr = '0;
    aref_req = 0; aref_cmd = 4'b0111; aref_done = 0;
    wr_req = 0; wr_cmd = 4'b0111; wr_addr = '0; wr_ba = '0; wr_data = '0;
    wr_go_aref = 0; wr_done_all = 0;
    rd_req = 0; rd_cmd = 4'b0111; rd_addr = '0; rd_ba = '0;
    rd_go_aref = 0; rd_done_all = 0;
  endtask

  int oe_cycles;

  initial begin
    rst_n = 0; init_done = 0;
    quiet_inputs();
    model_reset();
    #12;
    chk_eq("rst_cmd",  32'(sdram_cmd),    32'h7);
    chk_eq("rst_addr", 32'(sdram_addr),   32'h0);
    chk_eq("rst_dq",   32'(sdram_dq_out), 32'h0);
    chk_eq("rst_oe",   32'(sdram_dq_oe),  32'h0);
    chk_eq("rst_ens",  32'({aref_en, wr_en, rd_en}), 32'h0);
    @(posedge sdram_clk); #1;
    rst_n = 1;

    // init phase; init_done rises at cycle 10
    repeat (9) tick();
    init_cmd = 4'b0010; init_addr = 12'h033; init_done = 1;
    tick();
    chk_eq("t1_init_cmd",  32'(sdram_cmd),  32'h2);
    chk_eq("t1_init_addr", 32'(sdram_addr), 32'h033);
    init_cmd = 4'b0111; init_addr = '0;
    tick();
    chk_eq("t1_idle_nop", 32'(sdram_cmd), 32'h7);
    tick();
    chk_eq("t1_idle_nop2", 32'(sdram_cmd), 32'h7);

    // write/read tie alternation
    wr_req = 1; rd_req = 1;
    tick();
    chk_eq("t4_first_wr", 32'({wr_en, rd_en}), 32'h2);
    wr_req = 0; rd_req = 0; wr_done_all = 1;
    tick();
    wr_done_all = 0; wr_req = 1; rd_req = 1;
    tick();
    chk_eq("t4_second_rd", 32'({wr_en, rd_en}), 32'h1);
    wr_req = 0; rd_req = 0; rd_done_all = 1;
    tick();
    rd_done_all = 0;

    // write burst
    wr_req = 1;
    tick();
    chk_eq("t2_wr_en", 32'(wr_en), 32'h1);
    wr_req = 0; wr_cmd = 4'b0100; wr_data = 8'hA5; wr_addr = 12'h123; wr_ba = 2'd2;
    tick();
    chk_eq("t2_wr_en_off", 32'(wr_en),        32'h0);
    chk_eq("t2_cmd",       32'(sdram_cmd),    32'h4);
    chk_eq("t2_dq",        32'(sdram_dq_out), 32'hA5);
    chk_eq("t2_ba",        32'(sdram_ba),     32'h2);
    oe_cycles = int'(sdram_dq_oe);
    wr_cmd = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(i + 1);
      tick();
      oe_cycles += int'(sdram_dq_oe);
    end
    chk_eq("t2_oe_len", 32'(oe_cycles), 32'(BURST_LEN));

    // refresh during a write, write yields then regains the bus
    aref_req = 1;
    tick();
    aref_req = 0; wr_go_aref = 1;
    tick();
    chk_eq("t3_no_early_aref", 32'(aref_en), 32'h0);
    wr_go_aref = 0; wr_req = 1; aref_cmd = 4'b0001;
    tick();
    chk_eq("t3_aref_en", 32'({aref_en, wr_en}), 32'h2);
    tick();
    chk_eq("t3_aref_pin", 32'(sdram_cmd), 32'h1);
    aref_done = 1;
    tick();
    aref_done = 0;
    tick();
    chk_eq("t3_wr_regrant", 32'(wr_en), 32'h1);
    wr_req = 0; wr_done_all = 1;
    tick();
    wr_done_all = 0;

    // simultaneous refresh and write request in idle
    aref_req = 1; wr_req = 1;
    tick();
    chk_eq("t5_aref_only", 32'({aref_en, wr_en}), 32'h2);
    aref_req = 0;
    tick();
    aref_done = 1;
    tick();
    chk_eq("t5_wr_wait", 32'(wr_en), 32'h0);
    aref_done = 0;
    tick();
    chk_eq("t5_wr_after", 32'(wr_en), 32'h1);
    wr_req = 0;

    // async reset mid-burst
    wr_cmd = 4'b0100;
    tick();
    wr_cmd = 4'b0111;
    tick();
    chk_eq("t6_pre_oe", 32'(sdram_dq_oe), 32'h1);
    rst_n = 0;
    #2;
    chk_eq("t6_oe",  32'(sdram_dq_oe), 32'h0);
    chk_eq("t6_cmd", 32'(sdram_cmd),   32'h7);
    chk_eq("t6_ens", 32'({aref_en, wr_en, rd_en}), 32'h0);
    model_reset();
    quiet_inputs();
    init_done = 0;
    repeat (2) @(posedge sdram_clk);
    #1;
    rst_n = 1;
    init_cmd = 4'b0001;
    tick();
    chk_eq("t6_init_mux", 32'(sdram_cmd), 32'h1);
    init_cmd = 4'b0111; init_done = 1;
    tick();
    rd_done_all = 1;
    tick();
    chk_eq("t6_stray_done", 32'(sdram_cmd), 32'h7);
    rd_done_all = 0; rd_req = 1;
    tick();
    chk_eq("t6_rd_en", 32'(rd_en), 32'h1);
    rd_req = 0; rd_done_all = 1;
    tick();
    rd_done_all = 0;

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      init_done   = ($urandom_range(0, 7) != 0);
      init_cmd    = 4'($urandom);
      init_addr   = 12'($urandom);
      aref_req    = ($urandom_range(0, 19) == 0);
      aref_cmd    = 4'($urandom);
      aref_done   = ($urandom_range(0, 7) == 0);
      wr_req      = ($urandom_range(0, 2) == 0);
      rd_req      = ($urandom_range(0, 2) == 0);
      wr_cmd      = ($urandom_range(0, 3) == 0) ? 4'b0100 : 4'($urandom);
      wr_addr     = 12'($urandom);
      wr_ba       = 2'($urandom);
      wr_data     = 8'($urandom);
      rd_cmd      = 4'($urandom);
      rd_addr     = 12'($urandom);
      rd_ba       = 2'($urandom);
      wr_go_aref  = ($urandom_range(0, 15) == 0);
      wr_done_all = ($urandom_range(0, 11) == 0);
      rd_go_aref  = ($urandom_range(0, 15) == 0);
      rd_done_all = ($urandom_range(0, 11) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Command arbiter that sits directly downstream of the write engine, the read engine, the refresh block and the power-up init block. It grants the SDRAM bus to exactly one requester at a time and multiplexes that requester's {CS_n,RAS_n,CAS_n,WE_n}, address, bank and write data onto the SDRAM pins. It also drives the DQ output-enable during write bursts. Refresh has priority. Write and read alternate when both are pending.

Parameters:
ADDR_BITS, 12, SDRAM address width A11..A0
BA_BITS, 2, bank address width
DQ_BITS, 8, SDRAM data width (matches the 8-bit UART write path)
BURST_LEN, 4, write burst length in clocks; sets the dq_oe window

Ports:
sdram_clk  in  1  SDRAM clock; single clock domain
rst_n  in  1  asynchronous, active-low reset
init_done  in  1  level; power-up init sequence finished
init_cmd  in  4  init block command {CS_n,RAS_n,CAS_n,WE_n}
init_addr  in  ADDR_BITS  init block address (mode register value)
aref_req  in  1  refresh request (pulse or level)
aref_cmd  in  4  refresh block command
aref_done  in  1  1-cycle pulse; refresh sequence finished
aref_en  out  1  1-cycle grant pulse to the refresh block
wr_req  in  1  level; write engine waiting for a grant
wr_cmd  in  4  write engine command
wr_addr  in  ADDR_BITS  write engine address
wr_ba  in  BA_BITS  write engine bank
wr_data  in  DQ_BITS  write engine data
wr_go_aref  in  1  1-cycle pulse; write yields the bus for refresh
wr_done_all  in  1  1-cycle pulse; write job complete
wr_en  out  1  1-cycle grant pulse to the write engine
rd_req, rd_cmd, rd_addr, rd_ba, rd_go_aref, rd_done_all  in  same widths as the write set  read engine equivalents
rd_en  out  1  1-cycle grant pulse to the read engine
sdram_cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n} to the pins
sdram_addr  out  ADDR_BITS  address to the pins
sdram_ba  out  BA_BITS  bank to the pins
sdram_dq_out  out  DQ_BITS  write data to the pins
sdram_dq_oe  out  1  tri-state enable for DQ

Behaviour:
- FSM states: ARB_INIT (reset state), ARB_IDLE, ARB_AREF, ARB_WRITE, ARB_READ.
- ARB_INIT:
  - Pin mux selects init_cmd and init_addr; ba = 0.
  - Move to ARB_IDLE on the first cycle init_done = 1.
  - All requests are ignored in this state, but aref_req is still latched.
- aref_pend register:
  - Set when aref_req = 1.
  - Cleared on the cycle aref_en is issued.
  - If set and cleared in the same cycle, set wins.
- ARB_IDLE priority: aref_pend > write/read.
  - If both wr_req and rd_req are high, grant the side not recorded in last_grant.
  - last_grant resets to READ, so write wins the first tie.
- Grants:
  - On the IDLE->X transition, pulse the matching x_en for exactly 1 cycle. That cycle is the first cycle in state X.
  - last_grant updates only on write/read grants.
- ARB_AREF: exit to ARB_IDLE on aref_done.
- ARB_WRITE: exit to ARB_IDLE on wr_go_aref or wr_done_all. ARB_READ exits the same way on the rd_* pulses.
- Release and re-grant: a released requester re-asserts wr_req/rd_req. IDLE then serves the pending refresh first, so after a yield the order is refresh, then the requester.
- Pin mux by state:
  - IDLE drives NOP 4'b0111, addr 0, ba 0.
  - AREF drives aref_cmd, addr 0.
  - WRITE and READ drive the owner's cmd, addr and ba.
- Pin registers: all pin outputs, including sdram_dq_out, are registered together. Latency from engine outputs to pins is exactly 1 cycle and is identical for cmd, addr and data, so engine alignment is preserved.
- dq_oe:
  - In ARB_WRITE, wr_cmd == 4'b0100 loads oe_cnt = BURST_LEN.
  - sdram_dq_oe = (oe_cnt != 0), registered and aligned with the WRITE command at the pins.
  - oe_cnt decrements to 0. A reload while oe_cnt is nonzero restarts the count.
  - oe_cnt is forced to 0 when the state is not ARB_WRITE.
- Stray inputs: release pulses from a non-owner are ignored. x_done/go_aref while in IDLE are ignored.
- Simultaneous aref_req and wr_req in IDLE: the refresh is granted and the write waits.
- Reset values (async, mid-operation included):
  - state ARB_INIT, aref_pend 0, last_grant READ, oe_cnt 0.
  - sdram_cmd 4'b0111, sdram_addr 0, sdram_ba 0, sdram_dq_out 0, sdram_dq_oe 0.
  - aref_en, wr_en, rd_en 0.
- No state-dependent timing counters beyond oe_cnt. tRCD, tRP and tWR belong to the engines.

Decomposition:
- Shared header (the sdr_parameters include): CMD_NOP/PRE/AREF/ACT/WR/RD encodings, ADDR_BITS, BA_BITS, DQ_BITS, BURST_LEN. The arbiter state encodings live there too, so engines and benches can decode debug ports.
- One natural sub-module: sdram_pin_reg. It holds the registered cmd/addr/ba/dq/oe pin stage with its NOP reset values, and is reused by the read path's capture stage.

Test Plan:
1. Reset, then init_done high at cycle 10 with init_cmd = 4'b0010 -> sdram_cmd = 4'b0010 one cycle later; state ARB_IDLE at cycle 11; sdram_cmd = 4'b0111 thereafter.
2. wr_req high in IDLE, then engine drives wr_cmd = 4'b0100 with wr_data = 8'hA5 -> wr_en pulses 1 cycle; pins show 4'b0100 and dq 8'hA5 1 cycle later; dq_oe high for exactly 4 cycles.
3. aref_req 1-cycle pulse during ARB_WRITE, then wr_go_aref -> next cycle IDLE, aref_en pulse, ARB_AREF; after aref_done, re-asserted wr_req receives wr_en.
4. wr_req and rd_req rising together, twice in a row -> first grant wr_en, second grant rd_en (alternation).
5. aref_req and wr_req in the same IDLE cycle -> aref_en only; wr_en follows aref_done by 1 cycle.
6. rst_n low mid-burst with dq_oe = 1 -> dq_oe, aref_en/wr_en/rd_en 0 and sdram_cmd NOP immediately (async); state ARB_INIT; a rd_done_all pulse while in IDLE is ignored.
